// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch-controller state codes and
// instruction field accessors.
package cpu_pkg;

  localparam logic [5:0] OP_LOAD = 6'b010100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_BUBBLE = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Last FETCH cycle count value before the timeout fires (15 cycles total).
  localparam logic [3:0] TMO_LAST = 4'd14;

  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;

  function automatic logic [5:0] f_op(input logic [31:0] w);
    return w[OP_LSB +: 6];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] w);
    return w[RD_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] w);
    return w[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] w);
    return w[RS2_LSB +: 5];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the buffered instruction reads the
// non-zero destination of the previously issued load.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [5:0] last_op,
  input  logic [4:0] last_rd,
  input  logic [4:0] ibuf_rs1,
  input  logic [4:0] ibuf_rs2,
  output logic       hazard
);

  // Pure combinational compare against the last-issued record.
  always_comb begin
    hazard = (last_op == OP_LOAD) && (last_rd != 5'd0) &&
             ((ibuf_rs1 == last_rd) || (ibuf_rs2 == last_rd));
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetches one word at a time from instruction
// memory, issues it to decode, inserts one bubble on a load-use hazard,
// handles branch redirects (including ones arriving mid-fetch) and HALT.
// Optional feature: define FETCH_TIMEOUT_EN to add a 15-cycle fetch timeout
// that raises a sticky fetch_err and halts.
module ifetch_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [15:0] ins_pc,
  output logic        halted,
  output logic        fetch_err
);

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [15:0] ibuf_pc_q, ibuf_pc_d;
  logic [31:0] ins_q, ins_d;
  logic [15:0] ins_pc_q, ins_pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [5:0]  last_op_q, last_op_d;
  logic [4:0]  last_rd_q, last_rd_d;
  logic        fetch_err_q, fetch_err_d;
  logic        hazard;
  logic        issue;
  logic        timeout;

  hazard_detect u_hazard (
    .last_op  (last_op_q),
    .last_rd  (last_rd_q),
    .ibuf_rs1 (f_rs1(ibuf_q)),
    .ibuf_rs2 (f_rs2(ibuf_q)),
    .hazard   (hazard)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt_q, tmo_cnt_d;

  // Count FETCH cycles without ack; any other cycle restarts the count.
  always_comb begin
    tmo_cnt_d = 4'd0;
    if ((state_q == ST_FETCH) && !imem_ack) tmo_cnt_d = tmo_cnt_q + 4'd1;
  end

  assign timeout = (state_q == ST_FETCH) && !imem_ack && (tmo_cnt_q == TMO_LAST);

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= 4'd0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, issue and redirect handling.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ibuf_d      = ibuf_q;
    ibuf_pc_d   = ibuf_pc_q;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    last_op_d   = last_op_q;
    last_rd_d   = last_rd_q;
    fetch_err_d = fetch_err_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    ins_valid   = 1'b0;
    imem_req    = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (pend_vld_q || redirect) begin
            // Data belongs to the abandoned path: drop it and refetch.
            pc_d       = redirect ? redirect_pc : pend_pc_q;
            pend_vld_d = 1'b0;
          end else begin
            ibuf_d    = imem_rdata;
            ibuf_pc_d = pc_q;
            pc_d      = pc_q + 16'd1;
            state_d   = ST_ISSUE;
          end
        end else if (timeout) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end else if (redirect) begin
          // Address must stay stable until ack, so park the target.
          pend_vld_d = 1'b1;
          pend_pc_d  = redirect_pc;
        end
      end
      ST_ISSUE, ST_BUBBLE: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if ((state_q == ST_ISSUE) && hazard) begin
          ins_d   = 32'd0;
          state_d = ST_BUBBLE;
        end else begin
          issue = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      ins_d     = ibuf_q;
      ins_pc_d  = ibuf_pc_q;
      ins_valid = 1'b1;
      last_op_d = f_op(ibuf_q);
      last_rd_d = f_rd(ibuf_q);
      state_d   = (f_op(ibuf_q) == OP_HALT) ? ST_HALT : ST_FETCH;
    end
  end

  assign imem_addr = pc_q;
  assign ins       = ins_d;
  assign ins_pc    = ins_pc_d;
  assign halted    = (state_q == ST_HALT);
  assign fetch_err = fetch_err_q;

  // Control and architecturally visible state, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= 16'd0;
      ins_q       <= 32'd0;
      ins_pc_q    <= 16'd0;
      pend_vld_q  <= 1'b0;
      pend_pc_q   <= 16'd0;
      last_op_q   <= 6'd0;
      last_rd_q   <= 5'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
      last_op_q   <= last_op_d;
      last_rd_q   <= last_rd_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Instruction buffer holds data only; it is always written before use.
  always_ff @(posedge clk) begin
    ibuf_q    <= ibuf_d;
    ibuf_pc_q <= ibuf_pc_d;
  end

endmodule
